// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
//   Shared types and widths for the instruction/data memory arbiter.
//   Contents:
//     ARB_ADR_W / ARB_DAT_W / ARB_SEL_W  wishbone field widths (12 / 128 / 16)
//     lc3b_arb_state                      arbiter FSM states
//     lc3b_arb_requester                  identifies the I or D requester
//     arb_wd_width()                      watchdog counter width for a timeout
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

   localparam int ARB_ADR_W = 12;
   localparam int ARB_DAT_W = 128;
   localparam int ARB_SEL_W = 16;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_SERVE_I = 2'd1,
      ARB_SERVE_D = 2'd2
   } lc3b_arb_state;

   typedef enum logic {
      ARB_REQ_I = 1'b0,
      ARB_REQ_D = 1'b1
   } lc3b_arb_requester;

   // A disabled watchdog (0 cycles) still gets a 1-bit counter so that no
   // zero-width vectors are ever declared.
   function automatic int arb_wd_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Shares one wishbone memory port between the instruction-fetch master (I)
//   and the data master (D). One transaction is granted at a time; the winner's
//   request is passed straight through to memory and memory's ACK/RTY is
//   returned only to the winner. A watchdog turns a hung transaction into a
//   forced ACK+RTY and raises a sticky error flag.
//
// Parameters
//   DATA_PRIORITY   0: alternate I/D on ties, 1: D always wins a tie
//   TIMEOUT_CYCLES  grant cycles without a memory response before forced RTY
//                   (0 disables the watchdog)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_wb_*                     instruction requester (slave side)
//   d_wb_*                     data requester (slave side)
//     *_adr/_dat_m/_sel/_we    request fields from the master
//     *_cyc/_stb               request qualifiers
//     *_dat_s/_ack/_rty        response back to the master
//   mem_wb_*                   shared memory port (master side)
//   grant_i, grant_d           registered: which requester owns memory now
//   timeout_err                sticky watchdog expiry flag
// -----------------------------------------------------------------------------
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int DATA_PRIORITY  = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   // instruction requester
   input  logic [ARB_ADR_W-1:0] i_wb_adr,
   input  logic [ARB_DAT_W-1:0] i_wb_dat_m,
   input  logic [ARB_SEL_W-1:0] i_wb_sel,
   input  logic                 i_wb_we,
   input  logic                 i_wb_cyc,
   input  logic                 i_wb_stb,
   output logic [ARB_DAT_W-1:0] i_wb_dat_s,
   output logic                 i_wb_ack,
   output logic                 i_wb_rty,
   // data requester
   input  logic [ARB_ADR_W-1:0] d_wb_adr,
   input  logic [ARB_DAT_W-1:0] d_wb_dat_m,
   input  logic [ARB_SEL_W-1:0] d_wb_sel,
   input  logic                 d_wb_we,
   input  logic                 d_wb_cyc,
   input  logic                 d_wb_stb,
   output logic [ARB_DAT_W-1:0] d_wb_dat_s,
   output logic                 d_wb_ack,
   output logic                 d_wb_rty,
   // shared memory port
   output logic [ARB_ADR_W-1:0] mem_wb_adr,
   output logic [ARB_DAT_W-1:0] mem_wb_dat_m,
   output logic [ARB_SEL_W-1:0] mem_wb_sel,
   output logic                 mem_wb_we,
   output logic                 mem_wb_cyc,
   output logic                 mem_wb_stb,
   input  logic [ARB_DAT_W-1:0] mem_wb_dat_s,
   input  logic                 mem_wb_ack,
   input  logic                 mem_wb_rty,
   // status
   output logic                 grant_i,
   output logic                 grant_d,
   output logic                 timeout_err
);

   localparam int              WD_W     = arb_wd_width(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_MAX   = '1;
   localparam logic            WD_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic            D_WINS   = (DATA_PRIORITY != 0);

   lc3b_arb_state     state_reg, state_next;
   lc3b_arb_requester last_grant_reg, last_grant_next;
   logic [WD_W-1:0]   wd_reg, wd_next;
   logic              grant_i_reg, grant_d_reg;
   logic              timeout_err_reg, timeout_err_next;

   logic req_i, req_d;
   logic serving, serving_d, req_sel;
   logic mem_resp, wd_expired, finish, retry;

   assign req_i = i_wb_cyc & i_wb_stb;
   assign req_d = d_wb_cyc & d_wb_stb;

   assign serving   = (state_reg == ARB_SERVE_I) || (state_reg == ARB_SERVE_D);
   assign serving_d = (state_reg == ARB_SERVE_D);
   // The granted requester still asserting its request this cycle.
   assign req_sel   = serving & (serving_d ? req_d : req_i);

   assign mem_resp   = mem_wb_ack | mem_wb_rty;
   assign wd_expired = WD_EN && (wd_reg == WD_LIMIT);
   // A memory response in the expiry cycle wins over the watchdog.
   assign finish     = req_sel & (mem_resp | wd_expired);
   assign retry      = req_sel & (mem_wb_rty | (wd_expired & ~mem_wb_ack));

   // ---------------------------------------------------------------- flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ARB_IDLE;
         last_grant_reg  <= ARB_REQ_D;   // I wins the first tie
         wd_reg          <= '0;
         grant_i_reg     <= 1'b0;
         grant_d_reg     <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         last_grant_reg  <= last_grant_next;
         wd_reg          <= wd_next;
         grant_i_reg     <= (state_next == ARB_SERVE_I);
         grant_d_reg     <= (state_next == ARB_SERVE_D);
         timeout_err_reg <= timeout_err_next;
      end
   end

   // ------------------------------------------------------ next-state logic
   always_comb begin
      state_next       = state_reg;
      last_grant_next  = last_grant_reg;
      wd_next          = wd_reg;
      timeout_err_next = timeout_err_reg;
      case (state_reg)
         ARB_IDLE: begin
            // Every grant is entered from IDLE, so clearing here clears on entry.
            wd_next = '0;
            if (req_i && req_d) begin
               state_next = (D_WINS || (last_grant_reg == ARB_REQ_I)) ? ARB_SERVE_D
                                                                      : ARB_SERVE_I;
            end else if (req_i) begin
               state_next = ARB_SERVE_I;
            end else if (req_d) begin
               state_next = ARB_SERVE_D;
            end
         end
         ARB_SERVE_I, ARB_SERVE_D: begin
            if (!req_sel) begin
               // Master abandoned the cycle: release memory, no response.
               state_next = ARB_IDLE;
            end else if (finish) begin
               state_next      = ARB_IDLE;
               last_grant_next = serving_d ? ARB_REQ_D : ARB_REQ_I;
               if (!mem_resp) begin
                  timeout_err_next = 1'b1;
               end
            end else if (wd_reg != WD_MAX) begin
               wd_next = wd_reg + 1'b1;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   // ------------------------------------------------------------ output mux
   always_comb begin
      mem_wb_adr   = '0;
      mem_wb_dat_m = '0;
      mem_wb_sel   = '0;
      mem_wb_we    = 1'b0;
      mem_wb_cyc   = 1'b0;
      mem_wb_stb   = 1'b0;
      i_wb_ack     = 1'b0;
      i_wb_rty     = 1'b0;
      d_wb_ack     = 1'b0;
      d_wb_rty     = 1'b0;
      // CYC/STB follow the combined request so memory CYC drops in the same
      // cycle even when the I master (CYC tied high) withdraws only STB.
      if (state_reg == ARB_SERVE_I) begin
         mem_wb_adr   = i_wb_adr;
         mem_wb_dat_m = i_wb_dat_m;
         mem_wb_sel   = i_wb_sel;
         mem_wb_we    = i_wb_we;
         mem_wb_cyc   = req_i;
         mem_wb_stb   = req_i;
         i_wb_ack     = finish;
         i_wb_rty     = retry;
      end else if (state_reg == ARB_SERVE_D) begin
         mem_wb_adr   = d_wb_adr;
         mem_wb_dat_m = d_wb_dat_m;
         mem_wb_sel   = d_wb_sel;
         mem_wb_we    = d_wb_we;
         mem_wb_cyc   = req_d;
         mem_wb_stb   = req_d;
         d_wb_ack     = finish;
         d_wb_rty     = retry;
      end
   end

   // Read data goes to both masters; only the acknowledged one uses it.
   assign i_wb_dat_s  = mem_wb_dat_s;
   assign d_wb_dat_s  = mem_wb_dat_s;

   assign grant_i     = grant_i_reg;
   assign grant_d     = grant_d_reg;
   assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//   Two arbiters side by side: k=0 round-robin with a 4-cycle watchdog,
//   k=1 data-priority with the watchdog disabled. Random masters and a random
//   memory responder drive each one; a transaction-level model predicts who
//   owns memory, what memory sees and which master gets ACK/RTY.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

   localparam int N = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0][11:0]  i_adr, d_adr, m_adr;
   logic [N-1:0][127:0] i_dat_m, d_dat_m, m_dat_m, i_dat_s, d_dat_s, m_dat_s;
   logic [N-1:0][15:0]  i_sel, d_sel, m_sel;
   logic [N-1:0]        i_we, i_cyc, i_stb, i_ack, i_rty;
   logic [N-1:0]        d_we, d_cyc, d_stb, d_ack, d_rty;
   logic [N-1:0]        m_we, m_cyc, m_stb, m_ack, m_rty;
   logic [N-1:0]        g_i, g_d, t_err;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      memory_arbiter #(
         .DATA_PRIORITY (gi),
         .TIMEOUT_CYCLES((gi == 0) ? 4 : 0)
      ) u_dut (
         .clk(clk), .rst_n(rst_n),
         .i_wb_adr(i_adr[gi]), .i_wb_dat_m(i_dat_m[gi]), .i_wb_sel(i_sel[gi]),
         .i_wb_we(i_we[gi]), .i_wb_cyc(i_cyc[gi]), .i_wb_stb(i_stb[gi]),
         .i_wb_dat_s(i_dat_s[gi]), .i_wb_ack(i_ack[gi]), .i_wb_rty(i_rty[gi]),
         .d_wb_adr(d_adr[gi]), .d_wb_dat_m(d_dat_m[gi]), .d_wb_sel(d_sel[gi]),
         .d_wb_we(d_we[gi]), .d_wb_cyc(d_cyc[gi]), .d_wb_stb(d_stb[gi]),
         .d_wb_dat_s(d_dat_s[gi]), .d_wb_ack(d_ack[gi]), .d_wb_rty(d_rty[gi]),
         .mem_wb_adr(m_adr[gi]), .mem_wb_dat_m(m_dat_m[gi]), .mem_wb_sel(m_sel[gi]),
         .mem_wb_we(m_we[gi]), .mem_wb_cyc(m_cyc[gi]), .mem_wb_stb(m_stb[gi]),
         .mem_wb_dat_s(m_dat_s[gi]), .mem_wb_ack(m_ack[gi]), .mem_wb_rty(m_rty[gi]),
         .grant_i(g_i[gi]), .grant_d(g_d[gi]), .timeout_err(t_err[gi])
      );
   end

   // ------------------------------------------------------------ bookkeeping
   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc   = 0;
   string where = "";

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s %s: got %0h expected %0h", where, tag, got, exp);
      end
   endtask

   // ------------------------------------------------------ reference model
   // owner: 0 nobody, 1 I, 2 D. age: cycles of the current grant so far.
   int timeout_of [N] = '{4, 0};
   bit d_first    [N] = '{1'b0, 1'b1};
   int owner      [N];
   int age        [N];
   int dly        [N];   // cycle of the grant in which memory answers
   int kind       [N];   // 0/1 ack, 2 ack+rty, 3 rty only
   bit last_was_d [N];
   bit err_seen   [N];
   bit pi         [N];   // I master has a request outstanding
   bit pd         [N];   // D master has a request outstanding

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         owner[k] = 0; age[k] = 0; dly[k] = 0; kind[k] = 0;
         last_was_d[k] = 1'b1; err_seen[k] = 1'b0;
      end
   endtask

   task automatic new_i(input int k);
      pi[k]      = 1'b1;
      i_adr[k]   = 12'($urandom);
      i_sel[k]   = 16'($urandom);
      i_we[k]    = 1'($urandom_range(0, 1));
      i_dat_m[k] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic new_d(input int k);
      pd[k]      = 1'b1;
      d_adr[k]   = 12'($urandom);
      d_sel[k]   = 16'($urandom);
      d_we[k]    = 1'($urandom_range(0, 1));
      d_dat_m[k] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Masters and memory for one cycle of instance k.
   task automatic drive(input int k);
      bit sreq;
      if (pi[k]) begin
         if (owner[k] == 1 && $urandom_range(0, 24) == 0) pi[k] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
         new_i(k);
      end
      if (pd[k]) begin
         if (owner[k] == 2 && $urandom_range(0, 24) == 0) pd[k] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
         new_d(k);
      end
      i_cyc[k] = 1'b1;           // fetch side keeps CYC high permanently
      i_stb[k] = pi[k];
      d_cyc[k] = pd[k];
      d_stb[k] = pd[k];
      m_dat_s[k] = {$urandom, $urandom, $urandom, $urandom};
      m_ack[k] = 1'b0;
      m_rty[k] = 1'b0;
      sreq = (owner[k] == 1) ? pi[k] : (owner[k] == 2) ? pd[k] : 1'b0;
      if (sreq && age[k] == dly[k]) begin
         m_ack[k] = (kind[k] != 3);
         m_rty[k] = (kind[k] >= 2);
      end
   endtask

   task automatic check_and_advance(input int k);
      bit req_i, req_d, sreq, tmo, fin, rty, forced;
      int nxt;
      logic [11:0]  e_adr;
      logic [127:0] e_dat;
      logic [15:0]  e_sel;
      logic         e_we;
      where = $sformatf("k%0d c%0d", k, cyc);
      req_i  = pi[k];
      req_d  = pd[k];
      sreq   = (owner[k] == 1) ? req_i : (owner[k] == 2) ? req_d : 1'b0;
      tmo    = (timeout_of[k] != 0) && (age[k] == timeout_of[k]);
      fin    = sreq && (m_ack[k] || m_rty[k] || tmo);
      forced = sreq && tmo && !m_ack[k] && !m_rty[k];
      rty    = sreq && (m_rty[k] || forced);
      e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0;
      if (owner[k] == 1) begin
         e_adr = i_adr[k]; e_dat = i_dat_m[k]; e_sel = i_sel[k]; e_we = i_we[k];
      end else if (owner[k] == 2) begin
         e_adr = d_adr[k]; e_dat = d_dat_m[k]; e_sel = d_sel[k]; e_we = d_we[k];
      end
      check("grant_i", g_i[k], owner[k] == 1);
      check("grant_d", g_d[k], owner[k] == 2);
      check("mem_cyc", m_cyc[k], sreq);
      check("mem_stb", m_stb[k], sreq);
      check("mem_adr", m_adr[k], e_adr);
      check("mem_dat_m", m_dat_m[k], e_dat);
      check("mem_sel", m_sel[k], e_sel);
      check("mem_we", m_we[k], e_we);
      check("i_ack", i_ack[k], owner[k] == 1 && fin);
      check("i_rty", i_rty[k], owner[k] == 1 && rty);
      check("d_ack", d_ack[k], owner[k] == 2 && fin);
      check("d_rty", d_rty[k], owner[k] == 2 && rty);
      check("i_dat_s", i_dat_s[k], m_dat_s[k]);
      check("d_dat_s", d_dat_s[k], m_dat_s[k]);
      check("timeout_err", t_err[k], err_seen[k]);

      // What happens at the coming clock edge.
      nxt = owner[k];
      if (owner[k] == 0) begin
         if (req_i && req_d) nxt = (d_first[k] || !last_was_d[k]) ? 2 : 1;
         else if (req_i)     nxt = 1;
         else if (req_d)     nxt = 2;
         if (nxt != 0) begin
            age[k]  = 0;
            dly[k]  = $urandom_range(0, 6);
            kind[k] = $urandom_range(0, 3);
         end
      end else if (!sreq) begin
         $display("%s %s aborted", where, (owner[k] == 1) ? "I" : "D");
         nxt = 0;
      end else if (fin) begin
         $display("%s %s adr=%03h %s", where, (owner[k] == 1) ? "I" : "D", e_adr,
                  forced ? "timeout" : (rty ? "retry" : "ack"));
         last_was_d[k] = (owner[k] == 2);
         if (forced) err_seen[k] = 1'b1;
         if (owner[k] == 1) pi[k] = 1'b0;
         else               pd[k] = 1'b0;
         nxt = 0;
      end else begin
         age[k]++;
      end
      owner[k] = nxt;
   endtask

   // One clock cycle; entered just after a falling edge.
   task automatic step();
      for (int k = 0; k < N; k++) drive(k);
      #1;
      for (int k = 0; k < N; k++) check_and_advance(k);
      @(negedge clk);
      cyc++;
   endtask

   task automatic check_reset_outputs(input string phase);
      for (int k = 0; k < N; k++) begin
         where = $sformatf("k%0d %s", k, phase);
         check("grant_i", g_i[k], 1'b0);
         check("grant_d", g_d[k], 1'b0);
         check("mem_cyc", m_cyc[k], 1'b0);
         check("mem_stb", m_stb[k], 1'b0);
         check("mem_adr", m_adr[k], '0);
         check("i_ack", i_ack[k], 1'b0);
         check("d_ack", d_ack[k], 1'b0);
         check("timeout_err", t_err[k], 1'b0);
      end
   endtask

   initial begin
      bit found;
      i_adr = '0; i_dat_m = '0; i_sel = '0; i_we = '0; i_cyc = '0; i_stb = '0;
      d_adr = '0; d_dat_m = '0; d_sel = '0; d_we = '0; d_cyc = '0; d_stb = '0;
      m_dat_s = '0; m_ack = '0; m_rty = '0;
      for (int k = 0; k < N; k++) begin pi[k] = 1'b0; pd[k] = 1'b0; end
      model_reset();

      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      // Both masters request in the very first cycle: a tie.
      for (int k = 0; k < N; k++) begin new_i(k); new_d(k); end
      repeat (1500) step();

      // Pull reset in the middle of an I transaction on instance 0.
      found = 1'b0;
      for (int n = 0; n < 300 && !found; n++) begin
         if (owner[0] == 1) found = 1'b1;
         else step();
      end
      where = "rst_mid";
      check("reach_serve_i", found, 1'b1);
      if (found) begin
         for (int k = 0; k < N; k++) drive(k);
         #1;
         where = "rst_mid";
         check("pre_rst_grant_i", g_i[0], 1'b1);
         #1;
         rst_n = 1'b0;
         #1;
         check_reset_outputs("async_rst");
         @(negedge clk);
         rst_n = 1'b1;
         model_reset();
         for (int k = 0; k < N; k++) begin new_i(k); new_d(k); end
         repeat (1500) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
